// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: state encoding and helpers shared by prio_encoder_buf and prio_sel
package prio_enc_pkg;
  localparam int MAX_N = 64;
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL = 1'b1;
  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    return (MAX_N'(1) << idx) & ((MAX_N'(1) << n) - MAX_N'(1));
  endfunction
  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++)
      if ((64'd1 << r) >= 64'(v)) return r;
    return 32;
  endfunction
endpackage

// File: rtl/prio_sel.sv
// prio_sel: combinational lowest-set-bit encoder
module prio_sel import prio_enc_pkg::*; #(
  parameter int N = 8,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  // scan high to low so the lowest set bit is written last and wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = vec[i] ? IDX_W'(i) : idx;
  end
  assign found = |vec;
endmodule

// File: rtl/prio_encoder_buf.sv
// prio_encoder_buf: buffered priority encoder with valid/ready output; PRIO_ENC_RR_EN selects round-robin
module prio_encoder_buf import prio_enc_pkg::*; #(
  parameter int N = 8,
  parameter int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pend_any
);
  logic [N-1:0] pend_q, pend_d, cand;
  logic [IDX_W-1:0] idx_q, idx_d, sel;
  logic valid_q, valid_d, found, load;
  assign cand = pend_q | req;
  assign load = (valid_q == ST_EMPTY) | out_ready;
`ifdef PRIO_ENC_RR_EN
  logic [IDX_W-1:0] rr_q, rr_d, m_idx, u_idx;
  logic [N-1:0] mask;
  logic m_found;
  assign mask = ~((N'(1) << rr_q) - N'(1));
  prio_sel #(.N(N), .IDX_W(IDX_W)) u_sel_m (.vec(cand & mask), .idx(m_idx), .found(m_found));
  prio_sel #(.N(N), .IDX_W(IDX_W)) u_sel_u (.vec(cand), .idx(u_idx), .found(found));
  assign sel = m_found ? m_idx : u_idx;
  assign rr_d = (load && found) ? ((sel == IDX_W'(N - 1)) ? '0 : sel + IDX_W'(1)) : rr_q;
  // round-robin search start, advanced past every issued index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_q <= '0;
    else rr_q <= rr_d;
`else
  prio_sel #(.N(N), .IDX_W(IDX_W)) u_sel (.vec(cand), .idx(sel), .found(found));
`endif
  // next state: issue on load, otherwise hold the output and keep accumulating requests
  always_comb begin
    pend_d = cand;
    idx_d = idx_q;
    valid_d = valid_q;
    if (load) begin
      valid_d = found ? ST_FULL : ST_EMPTY;
      idx_d = found ? sel : idx_q;
      pend_d = found ? cand & ~N'(onehot(int'(sel), N)) : cand;
    end
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q <= '0;
      idx_q <= '0;
      valid_q <= ST_EMPTY;
    end else begin
      pend_q <= pend_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
    end
  assign out_idx = idx_q;
  assign out_valid = valid_q;
  assign pend_any = |pend_q;
endmodule

// File: tb/tb_prio_encoder_buf.sv
// tb_prio_encoder_buf: scoreboard bench for prio_encoder_buf at N=4
module tb_prio_encoder_buf;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic out_ready = 1'b0;
  logic [1:0] out_idx;
  logic out_valid, pend_any;
  int passed = 0, total = 0;
  int exp_q[$];
  logic [N-1:0] m_pend = '0;
  logic m_valid = 1'b0;
  int m_idx = 0, m_rr = 0;

  prio_encoder_buf #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] c, input int start);
    for (int k = 0; k < N; k++)
      if (c[(start + k) % N]) return (start + k) % N;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_valid = 1'b0; m_idx = 0; m_rr = 0;
    exp_q.delete();
  endtask

  task automatic step();
    logic [N-1:0] cand;
    int s, e, start;
    if (out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0)
        $display("FAIL issue: out_idx=%0d issued but nothing expected", out_idx);
      else begin
        e = exp_q.pop_front();
        if (out_idx !== 2'(e)) $display("FAIL issue: out_idx=%0d expected %0d", out_idx, e);
        else passed++;
      end
    end
    cand = m_pend | req;
`ifdef PRIO_ENC_RR_EN
    start = m_rr;
`else
    start = 0;
`endif
    if (!m_valid || out_ready) begin
      if (cand != 0) begin
        s = pick(cand, start);
        m_idx = s; m_valid = 1'b1;
        m_pend = cand & ~(N'(1) << s);
        m_rr = (s + 1) % N;
        exp_q.push_back(s);
      end else m_valid = 1'b0;
    end else m_pend = cand;
    @(posedge clk); #1;
    total++;
    if (out_valid !== m_valid || out_idx !== 2'(m_idx) || pend_any !== (m_pend != 0))
      $display("FAIL cycle: valid/idx/pend_any=%0b/%0d/%0b expected %0b/%0d/%0b",
               out_valid, out_idx, pend_any, m_valid, m_idx, m_pend != 0);
    else passed++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    out_ready = 1'b1; req = 4'b0100; step();
    total++;
    if (out_idx !== 2'd2 || out_valid !== 1'b1) $display("FAIL single: idx/valid=%0d/%0b expected 2/1", out_idx, out_valid);
    else passed++;
    req = '0; step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_empty: valid=%0b expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_multi();
    out_ready = 1'b1; req = 4'b1010; step();
    total++;
    if (out_idx !== 2'd1 || out_valid !== 1'b1) $display("FAIL multi_first: idx/valid=%0d/%0b expected 1/1", out_idx, out_valid);
    else passed++;
    req = '0; step();
    total++;
    if (out_idx !== 2'd3 || out_valid !== 1'b1) $display("FAIL multi_second: idx/valid=%0d/%0b expected 3/1", out_idx, out_valid);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL multi_empty: valid=%0b expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0; req = 4'b0001; step();
    req = 4'b1000; step();
    req = '0; step();
    total++;
    if (out_idx !== 2'd0 || out_valid !== 1'b1 || pend_any !== 1'b1)
      $display("FAIL stall_hold: idx/valid/pend_any=%0d/%0b/%0b expected 0/1/1", out_idx, out_valid, pend_any);
    else passed++;
    out_ready = 1'b1; step();
    total++;
    if (out_idx !== 2'd3 || out_valid !== 1'b1 || pend_any !== 1'b0)
      $display("FAIL stall_release: idx/valid/pend_any=%0d/%0b/%0b expected 3/1/0", out_idx, out_valid, pend_any);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL stall_empty: valid=%0b expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset();
    out_ready = 1'b0; req = 4'b1111; step(); step();
    total++;
    if (out_valid !== 1'b1 || pend_any !== 1'b1) $display("FAIL reset_pre: valid/pend_any=%0b/%0b expected 1/1", out_valid, pend_any);
    else passed++;
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_idx !== 2'd0 || pend_any !== 1'b0)
      $display("FAIL reset_async: valid/idx/pend_any=%0b/%0d/%0b expected 0/0/0", out_valid, out_idx, pend_any);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || pend_any !== 1'b0) $display("FAIL reset_held: valid/pend_any=%0b/%0b expected 0/0", out_valid, pend_any);
    else passed++;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_hold_all();
    int e;
    do_reset();
    out_ready = 1'b1; req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
`ifdef PRIO_ENC_RR_EN
      e = i % N;
`else
      e = 0;
`endif
      total++;
      if (out_idx !== 2'(e) || out_valid !== 1'b1) $display("FAIL hold_all[%0d]: idx=%0d expected %0d", i, out_idx, e);
      else passed++;
    end
    req = '0;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_requeue();
    out_ready = 1'b0; req = 4'b0001; step();
    step();
    total++;
    if (out_idx !== 2'd0 || pend_any !== 1'b1) $display("FAIL requeue_pend: idx/pend_any=%0d/%0b expected 0/1", out_idx, pend_any);
    else passed++;
    req = '0; out_ready = 1'b1; step();
    total++;
    if (out_idx !== 2'd0 || out_valid !== 1'b1 || pend_any !== 1'b0)
      $display("FAIL requeue_issue: idx/valid/pend_any=%0d/%0b/%0b expected 0/1/0", out_idx, out_valid, pend_any);
    else passed++;
    step();
  endtask

  task automatic test_idle();
    do_reset();
    out_ready = 1'b1; req = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || pend_any !== 1'b0) $display("FAIL idle[%0d]: valid/pend_any=%0b/%0b expected 0/0", i, out_valid, pend_any);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req = '0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) $display("FAIL drain: %0d issues outstanding, valid=%0b expected 0/0", exp_q.size(), out_valid);
    else passed++;
  endtask

  initial begin
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_idx !== 2'd0 || pend_any !== 1'b0)
      $display("FAIL reset_init: valid/idx/pend_any=%0b/%0d/%0b expected 0/0/0", out_valid, out_idx, pend_any);
    else passed++;
    test_single();
    test_multi();
    test_stall();
    test_reset();
    test_hold_all();
    test_requeue();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
